// File: rtl/ps2_device_if.sv
// Purpose: register-bus bundle between a CPU-style master and the PS/2 device port.
// Latency: pure wiring; read data is combinational in the device.
// Backpressure: none; single-cycle write strobe, reads are always valid.
// Signals: I_ADDR register select, I_WRITE write strobe, I_WRDATA write data, O_RDDATA read data.
interface ps2_device_if;
    logic [1:0] I_ADDR;
    logic       I_WRITE;
    logic [7:0] I_WRDATA;
    logic [7:0] O_RDDATA;

    modport master (
        output I_ADDR,
        output I_WRITE,
        output I_WRDATA,
        input  O_RDDATA
    );

    modport slave (
        input  I_ADDR,
        input  I_WRITE,
        input  I_WRDATA,
        output O_RDDATA
    );
endinterface

// File: rtl/ps2_device.sv
// Purpose: device-side (keyboard-end) PS/2 port: generates PS2CLK, sends bytes, receives host commands with ACK.
// Latency: one bit per PS2CLK period (2*HALFPER I_CLK); reads are combinational, writes take effect next edge.
// Backpressure: addr2 write is dropped while a byte is pending; host inhibit aborts a frame and it retries after GAPCYC idle.
// Ports:
//   I_CLK       system clock
//   I_RST       asynchronous reset, active-high; releases both pads immediately
//   bus         register interface (addr 0 status/flags, addr 2 tx/rx byte)
//   IO_PS2CLK   open-drain clock pad, drives 0 or z
//   IO_PS2DATA  open-drain data pad, drives 0 or z
module ps2_device #(
    parameter int HALFPER = 1000,
    parameter int GAPCYC  = 2000
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    ps2_device_if.slave   bus,
    inout  wire           IO_PS2CLK,
    inout  wire           IO_PS2DATA
);

    localparam int TW = (HALFPER > 1) ? $clog2(HALFPER) : 1;
    localparam int GW = $clog2(GAPCYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(HALFPER - 1);
    localparam logic [GW-1:0] GMAX = GW'(GAPCYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_ACK
    } state_e;

    // Phase encoding: HI = device releases clock, LO = device pulls clock low.
    localparam logic PH_HI = 1'b0;
    localparam logic PH_LO = 1'b1;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          phase_q, phase_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   shift_q, shift_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          clkdrv_q, clkdrv_d;
    logic          datdrv_q, datdrv_d;
    logic          txpend_q, txpend_d;
    logic [7:0]    txbyte_q, txbyte_d;
    logic [7:0]    rxbyte_q, rxbyte_d;
    logic          rxvalid_q, rxvalid_d;
    logic          perr_q, perr_d;

    logic          sclk_meta_q, sclk_q;
    logic          sdat_meta_q, sdat_q;

    logic          wrap;
    logic          busy;
    logic [10:0]   tx_frame;
    logic [9:0]    rx_frame;

    // Pads: only registered drive enables reach the lines.
    assign IO_PS2CLK  = clkdrv_q ? 1'b0 : 1'bz;
    assign IO_PS2DATA = datdrv_q ? 1'b0 : 1'bz;

    // Synchronizers reset to the idle-bus level so no false request-to-send is seen out of reset.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            sclk_meta_q <= 1'b1;
            sclk_q      <= 1'b1;
            sdat_meta_q <= 1'b1;
            sdat_q      <= 1'b1;
        end else begin
            sclk_meta_q <= IO_PS2CLK;
            sclk_q      <= sclk_meta_q;
            sdat_meta_q <= IO_PS2DATA;
            sdat_q      <= sdat_meta_q;
        end
    end

    assign wrap = (timer_q == TMAX);
    assign busy = (state_q != ST_IDLE);

    // Start bit first on the wire, odd parity, stop bit last.
    assign tx_frame = {1'b1, ~^txbyte_q, txbyte_q, 1'b0};
    // The frame as it will look once the current sample is shifted in: data, parity, stop.
    assign rx_frame = {sdat_q, shift_q[9:1]};

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        phase_d   = phase_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        gap_d     = '0;
        clkdrv_d  = clkdrv_q;
        datdrv_d  = datdrv_q;
        txpend_d  = txpend_q;
        txbyte_d  = txbyte_q;
        rxbyte_d  = rxbyte_q;
        rxvalid_d = rxvalid_q;
        perr_d    = perr_q;

        // Software side first so that hardware flag sets below take precedence.
        if (bus.I_WRITE) begin
            if (bus.I_ADDR == 2'd0) begin
                rxvalid_d = bus.I_WRDATA[0];
                perr_d    = bus.I_WRDATA[1];
            end else if (bus.I_ADDR == 2'd2 && !txpend_q) begin
                txbyte_d = bus.I_WRDATA;
                txpend_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                timer_d  = '0;
                phase_d  = PH_HI;
                bitcnt_d = '0;
                clkdrv_d = 1'b0;
                datdrv_d = 1'b0;
                if (sclk_q && sdat_q) begin
                    gap_d = (gap_q == GMAX) ? gap_q : gap_q + 1'b1;
                end
                // Host request-to-send wins over a pending transmit.
                if (sclk_q && !sdat_q) begin
                    state_d = ST_RX;
                    shift_d = '0;
                    gap_d   = '0;
                end else if (txpend_q && gap_q == GMAX) begin
                    state_d  = ST_TX;
                    datdrv_d = ~tx_frame[0];
                    shift_d  = {1'b0, tx_frame[10:1]};
                    gap_d    = '0;
                end
            end

            ST_TX: begin
                timer_d = wrap ? '0 : timer_q + 1'b1;
                if (wrap) begin
                    if (phase_q == PH_HI) begin
                        if (!sclk_q) begin
                            // Host inhibit: abandon the frame, keep the byte pending for a retry.
                            state_d  = ST_IDLE;
                            clkdrv_d = 1'b0;
                            datdrv_d = 1'b0;
                        end else begin
                            phase_d  = PH_LO;
                            clkdrv_d = 1'b1;
                        end
                    end else if (bitcnt_q == 4'd10) begin
                        state_d  = ST_IDLE;
                        clkdrv_d = 1'b0;
                        datdrv_d = 1'b0;
                        txpend_d = 1'b0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        phase_d  = PH_HI;
                        clkdrv_d = 1'b0;
                        datdrv_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[10:1]};
                    end
                end
            end

            ST_RX: begin
                timer_d  = wrap ? '0 : timer_q + 1'b1;
                datdrv_d = 1'b0;
                if (wrap) begin
                    if (phase_q == PH_HI) begin
                        phase_d  = PH_LO;
                        clkdrv_d = 1'b1;
                    end else begin
                        // Last cycle of LO is the PS2CLK rising edge: take the bit now.
                        shift_d  = {1'b0, rx_frame};
                        phase_d  = PH_HI;
                        clkdrv_d = 1'b0;
                        if (bitcnt_q == 4'd9) begin
                            state_d  = ST_ACK;
                            bitcnt_d = '0;
                            datdrv_d = 1'b1;
                            if ((^rx_frame[8:0]) && rx_frame[9]) begin
                                rxbyte_d  = rx_frame[7:0];
                                rxvalid_d = 1'b1;
                            end else begin
                                perr_d = 1'b1;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_ACK: begin
                timer_d = wrap ? '0 : timer_q + 1'b1;
                if (wrap) begin
                    if (phase_q == PH_HI) begin
                        phase_d  = PH_LO;
                        clkdrv_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        clkdrv_d = 1'b0;
                        datdrv_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                clkdrv_d = 1'b0;
                datdrv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            phase_q   <= PH_HI;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            gap_q     <= '0;
            clkdrv_q  <= 1'b0;
            datdrv_q  <= 1'b0;
            txpend_q  <= 1'b0;
            txbyte_q  <= 8'h00;
            rxbyte_q  <= 8'h00;
            rxvalid_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            phase_q   <= phase_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            gap_q     <= gap_d;
            clkdrv_q  <= clkdrv_d;
            datdrv_q  <= datdrv_d;
            txpend_q  <= txpend_d;
            txbyte_q  <= txbyte_d;
            rxbyte_q  <= rxbyte_d;
            rxvalid_q <= rxvalid_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        bus.O_RDDATA = rxbyte_q;
        if (bus.I_ADDR == 2'd0) begin
            bus.O_RDDATA = {4'b0000, perr_q, txpend_q, busy, rxvalid_q};
        end
    end

endmodule

// File: tb/tb_ps2_device.sv
module tb_ps2_device;

    localparam int HALFPER = 10;
    localparam int GAPCYC  = 20;

    logic I_CLK;
    logic I_RST;
    logic host_clk_lo;
    logic host_dat_lo;

    wire ps2clk;
    wire ps2dat;

    pullup (ps2clk);
    pullup (ps2dat);
    assign ps2clk = host_clk_lo ? 1'b0 : 1'bz;
    assign ps2dat = host_dat_lo ? 1'b0 : 1'bz;

    ps2_device_if bus_if ();

    ps2_device #(
        .HALFPER (HALFPER),
        .GAPCYC  (GAPCYC)
    ) dut (
        .I_CLK      (I_CLK),
        .I_RST      (I_RST),
        .bus        (bus_if),
        .IO_PS2CLK  (ps2clk),
        .IO_PS2DATA (ps2dat)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    initial I_CLK = 1'b0;
    always #20 I_CLK = ~I_CLK;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge I_CLK);
        bus_if.I_ADDR   = a;
        bus_if.I_WRDATA = d;
        bus_if.I_WRITE  = 1'b1;
        @(negedge I_CLK);
        bus_if.I_WRITE  = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        bus_if.I_ADDR = a;
        #1;
        d = bus_if.O_RDDATA;
    endtask

    task automatic wait_idle(input int timeout, output bit ok);
        logic [7:0] s;
        ok = 1'b0;
        for (int i = 0; i < timeout; i++) begin
            @(negedge I_CLK);
            cpu_read(2'd0, s);
            if (!s[1]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_edge(input bit rising, input int timeout, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = ps2clk;
        for (int i = 0; i < timeout; i++) begin
            @(negedge I_CLK);
            if (rising ? (!prev && ps2clk) : (prev && !ps2clk)) begin
                ok = 1'b1;
                break;
            end
            prev = ps2clk;
        end
    endtask

    // Host receiver: samples data on each PS2CLK falling edge and measures half-periods.
    task automatic host_capture(input int timeout, output logic [10:0] bits, output int nfall,
                                output int first_fall, output int lo_bad, output int hi_bad);
        logic prev;
        int   run;
        bits = '0; nfall = 0; first_fall = -1; lo_bad = 0; hi_bad = 0;
        prev = ps2clk;
        run  = 0;
        for (int cyc = 1; cyc <= timeout && nfall < 11; cyc++) begin
            @(negedge I_CLK);
            if (ps2clk != prev) begin
                if (!prev && run != HALFPER) lo_bad++;
                if (prev && nfall > 0 && run != HALFPER) hi_bad++;
                if (prev) begin
                    bits[nfall] = ps2dat;
                    if (nfall == 0) first_fall = cyc;
                    nfall++;
                end
                run = 1;
            end else begin
                run++;
            end
            prev = ps2clk;
        end
    endtask

    task automatic check_tx_frame(input string tag, input logic [10:0] bits, input int nfall);
        logic [7:0] e;
        e = tx_exp_q.pop_front();
        check({tag, "_nfall"}, nfall, 11);
        check({tag, "_start"}, bits[0], 1'b0);
        check({tag, "_data"}, bits[8:1], e);
        check({tag, "_parity"}, bits[9], ~^e);
        check({tag, "_stop"}, bits[10], 1'b1);
    endtask

    // Host transmitter: inhibit 100 us, request-to-send, then clock out nsend bits on device falls.
    task automatic host_send(input logic [7:0] data, input bit flip, input int nsend);
        logic [9:0] b;
        bit         ok;
        b = {1'b1, (~^data) ^ flip, data};
        host_clk_lo = 1'b1;
        repeat (2500) @(negedge I_CLK);
        host_dat_lo = 1'b1;
        repeat (5) @(negedge I_CLK);
        host_clk_lo = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            wait_edge(1'b0, 4 * HALFPER + 10, ok);
            check("rx_fall", ok, 1);
            if (!ok) return;
            host_dat_lo = ~b[i];
        end
        if (nsend < 10) return;
        wait_edge(1'b0, 4 * HALFPER + 10, ok);
        check("ack_fall", ok, 1);
        check("ack_low", ps2dat, 1'b0);
        wait_idle(4 * HALFPER, ok);
        check("rx_done", ok, 1);
        check("rx_lines_released", {ps2clk, ps2dat}, 2'b11);
    endtask

    initial begin
        logic [7:0]  s;
        logic [10:0] bits;
        int          nfall, ff, lo_bad, hi_bad;
        bit          ok;

        I_RST           = 1'b1;
        host_clk_lo     = 1'b0;
        host_dat_lo     = 1'b0;
        bus_if.I_ADDR   = 2'd0;
        bus_if.I_WRITE  = 1'b0;
        bus_if.I_WRDATA = 8'h00;
        repeat (3) @(negedge I_CLK);
        I_RST = 1'b0;
        @(negedge I_CLK);

        // Reset state
        cpu_read(2'd0, s); check("reset_status", s, 8'h00);
        cpu_read(2'd2, s); check("reset_rxbyte", s, 8'h00);
        cpu_read(2'd1, s); check("reset_rxbyte_a1", s, 8'h00);
        check("reset_pads", {ps2clk, ps2dat}, 2'b11);

        // Device-to-host 0x1C
        cpu_write(2'd2, 8'h1C); tx_exp_q.push_back(8'h1C);
        cpu_read(2'd0, s); check("tx_pend_set", s[2], 1'b1);
        host_capture(2000, bits, nfall, ff, lo_bad, hi_bad);
        check_tx_frame("tx1c", bits, nfall);
        check("tx1c_low_len", lo_bad, 0);
        check("tx1c_high_len", hi_bad, 0);
        wait_idle(4 * HALFPER, ok); check("tx1c_done", ok, 1);
        cpu_read(2'd0, s); check("tx1c_status", s, 8'h00);

        // Host-to-device 0xED, good frame
        rx_exp_q.push_back(8'hED);
        host_send(8'hED, 1'b0, 10);
        cpu_read(2'd0, s); check("rxed_status", s, 8'h01);
        cpu_read(2'd2, s); check("rxed_byte", s, rx_exp_q.pop_front());
        cpu_write(2'd0, 8'h00);
        cpu_read(2'd0, s); check("rxvalid_clear", s, 8'h00);

        // Host-to-device 0x3C with bad parity: rxbyte must keep 0xED
        host_send(8'h3C, 1'b1, 10);
        cpu_read(2'd0, s); check("perr_status", s, 8'h08);
        cpu_read(2'd2, s); check("perr_rxbyte_kept", s, 8'hED);
        cpu_write(2'd0, 8'h00);
        cpu_read(2'd0, s); check("perr_clear", s, 8'h00);

        // Transmit 0x5A, host inhibits during the 5th HI phase, then retry
        cpu_write(2'd2, 8'h5A); tx_exp_q.push_back(8'h5A);
        for (int k = 0; k < 4; k++) begin
            wait_edge(1'b1, 200, ok);
            check("inh_rise", ok, 1);
        end
        repeat (2) @(negedge I_CLK);
        host_clk_lo = 1'b1;
        wait_idle(HALFPER + 3, ok); check("inh_release", ok, 1);
        cpu_read(2'd0, s); check("inh_status", s, 8'h04);
        check("inh_data_released", ps2dat, 1'b1);
        repeat (50) @(negedge I_CLK);
        cpu_read(2'd0, s); check("inh_hold_status", s, 8'h04);
        host_clk_lo = 1'b0;
        host_capture(500, bits, nfall, ff, lo_bad, hi_bad);
        check("retry_gap", (ff >= GAPCYC + HALFPER) && (ff <= GAPCYC + HALFPER + 6), 1);
        check_tx_frame("tx5a", bits, nfall);
        wait_idle(4 * HALFPER, ok); check("tx5a_done", ok, 1);
        cpu_read(2'd0, s); check("tx5a_status", s, 8'h00);

        // Request-to-send and pending TX together: RX first, second write ignored
        host_clk_lo = 1'b1;
        repeat (5) @(negedge I_CLK);
        cpu_write(2'd2, 8'hA5); tx_exp_q.push_back(8'hA5);
        cpu_write(2'd2, 8'h77);
        cpu_read(2'd0, s); check("prio_pend", s, 8'h04);
        rx_exp_q.push_back(8'h42);
        host_send(8'h42, 1'b0, 10);
        host_capture(500, bits, nfall, ff, lo_bad, hi_bad);
        check_tx_frame("txa5", bits, nfall);
        wait_idle(4 * HALFPER, ok); check("txa5_done", ok, 1);
        cpu_read(2'd0, s); check("prio_status", s, 8'h01);
        cpu_read(2'd2, s); check("prio_rxbyte", s, rx_exp_q.pop_front());
        cpu_write(2'd0, 8'h00);

        // Reset in the middle of a host frame, while the device pulls PS2CLK low
        host_send(8'h66, 1'b0, 5);
        I_RST       = 1'b1;
        host_clk_lo = 1'b0;
        host_dat_lo = 1'b0;
        #1;
        check("rst_pads", {ps2clk, ps2dat}, 2'b11);
        cpu_read(2'd0, s); check("rst_status", s, 8'h00);
        repeat (3) @(negedge I_CLK);
        I_RST = 1'b0;
        @(negedge I_CLK);
        cpu_read(2'd2, s); check("rst_rxbyte", s, 8'h00);
        rx_exp_q.push_back(8'h99);
        host_send(8'h99, 1'b0, 10);
        cpu_read(2'd0, s); check("post_rst_status", s, 8'h01);
        cpu_read(2'd2, s); check("post_rst_rxbyte", s, rx_exp_q.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
